mac_ctrl: RTL and testbench
===========================

# mac_ctrl

Control FSM for the complex multiply-accumulate datapath. It sits directly upstream of the MAC datapath and drives every load, select, init and multiplier-start control of that datapath. It sequences one 4-term complex dot product, sum of x_i·y_i for i = 0..3, per request. It loads the operand registers, clears the accumulator, then for each term starts the serial complex multiplier, waits for its completion and commits the sum.

## Interface
- TIMEOUT_CYC, 64: maximum cycles spent waiting for done3 per term. Used only with the watchdog compiled in.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request; level-sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; the datapath ans is valid from this cycle on.
- err  out  1  one-cycle pulse on watchdog abort; constant 0 without the macro.
- ld_x  out  4  bit i drives ld_xi.
- ld_y  out  4  bit i drives ld_yi.
- sel_xi, sel_yi  out  2  operand mux selects; always equal to each other.
- init_re, init_imag  out  1  synchronous clear of the accumulator halves.
- ld_re, ld_imag  out  1  accumulator load strobes; always equal to each other.
- start3  out  1  multiplier start pulse.
- done3  in  1  multiplier completion.

## Operation
- States: IDLE, LOAD, MSTART, MWAIT, ACC, FIN, plus ABORT when the watchdog is compiled in.
- 2-bit term counter cnt. sel_xi = sel_yi = cnt in MSTART, MWAIT and ACC; 0 elsewhere.
- IDLE:
  - All strobes 0.
  - start=1 → LOAD.
- LOAD, 1 cycle:
  - ld_x = ld_y = 4'hF.
  - init_re = init_imag = 1.
  - cnt ← 0.
  - → MSTART.
- MSTART, 1 cycle:
  - start3 = 1.
  - → MWAIT.
- MWAIT:
  - Holds the selects.
  - done3=1 → ACC; otherwise stay.
- ACC, 1 cycle:
  - ld_re = ld_imag = 1.
  - cnt=3 → FIN; otherwise cnt ← cnt+1 and → MSTART.
- FIN, 1 cycle:
  - done = 1.
  - → IDLE.
- Every strobe output is a Moore decode of the state: a single-cycle pulse, never held across states.
- done3 is ignored outside MWAIT. This includes done3 arriving in MSTART in the same cycle as start3.
- start while busy is ignored and is not queued. start held high through FIN restarts from IDLE on the next sampling edge. That gives back-to-back operations with 1 IDLE cycle between them.
- Reset (rst=0) takes effect on the next edge regardless of state:
  - → IDLE, cnt=0, watchdog=0.
  - All outputs 0.
  - A mid-operation reset abandons the accumulation without asserting done. The accumulator is not cleared by this block.

## Timing
- Count the edge that samples start in IDLE as edge 0. LOAD occupies cycle 1.
- L = multiplier latency: done3 asserted L cycles after the start3 cycle, L ≥ 1.
- Each term occupies L+2 cycles: MSTART, L cycles of MWAIT, ACC.
- done is high in cycle 2+4(L+2). busy is high from cycle 1 through that cycle inclusive.
- Reset values:
  - busy = done = err = start3 = 0.
  - ld_x = ld_y = 0.
  - sel = 0.
  - init and ld strobes = 0.

## Configuration
- MAC_CTRL_TIMEOUT_EN defined:
  - An 8-bit watchdog counts the cycles spent in MWAIT and is cleared on entry to MWAIT.
  - If it reaches TIMEOUT_CYC with done3 still 0 → ABORT, 1 cycle: err=1, no ld_re, no done. Then → IDLE.
- Undefined:
  - No watchdog logic; MWAIT waits indefinitely.
  - err tied to 0; no ABORT state.

## Test plan
- Reset: hold rst=0 for 3 cycles with start=1. → busy, done and all strobes stay 0; first op begins only after rst=1.
- Nominal: multiplier model with L=3, pulse start once. → sel sequence 0,1,2,3; exactly 4 start3 and 4 ld_re pulses; one init pulse in cycle 1; done in cycle 22.
- Variable latency: L=1,5,2,9 across the four terms. → each ld_re occurs exactly 1 cycle after the corresponding done3; sel is stable throughout each MWAIT.
- Spurious done3: assert done3 during LOAD and MSTART. → ignored; the term completes only on a done3 seen in MWAIT.
- Reset mid-op: rst=0 during MWAIT of term 2. → IDLE next edge, no done. A restart then produces a full 4-term sequence beginning with LOAD.
- Watchdog (macro on, TIMEOUT_CYC=16): done3 never asserted. → err pulse in the 17th cycle after start3, then IDLE; done never asserted.

Source files
------------

// File: rtl/mac_ctrl.sv
// Control sequencer for the complex MAC datapath: one 4-term complex dot product per request.
// Define MAC_CTRL_TIMEOUT_EN to add the MWAIT watchdog and the ABORT state.
module mac_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic [3:0] ld_x_o,
   output logic [3:0] ld_y_o,
   output logic [1:0] sel_xi_o,
   output logic [1:0] sel_yi_o,
   output logic       init_re_o,
   output logic       init_imag_o,
   output logic       ld_re_o,
   output logic       ld_imag_o,
   output logic       start3_o,
   input  logic       done3_i
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StLoad   = 3'd1;
   localparam logic [2:0] StMstart = 3'd2;
   localparam logic [2:0] StMwait  = 3'd3;
   localparam logic [2:0] StAcc    = 3'd4;
   localparam logic [2:0] StFin    = 3'd5;

   logic [2:0] state_q, state_d;
   logic [1:0] cnt_q, cnt_d;

`ifdef MAC_CTRL_TIMEOUT_EN
   localparam logic [2:0] StAbort  = 3'd6;
   // Compare against TIMEOUT_CYC-1 so ABORT follows exactly TIMEOUT_CYC cycles of MWAIT.
   localparam logic [7:0] WdogLast = 8'(TIMEOUT_CYC - 1);

   logic [7:0] wdog_q, wdog_d;
   logic       wdog_expired;

   assign wdog_expired = (wdog_q == WdogLast);
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT_CYC;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef MAC_CTRL_TIMEOUT_EN
      wdog_d  = wdog_q;
`endif
      case (state_q)
         StIdle: begin
            if (start_i) state_d = StLoad;
         end
         StLoad: begin
            cnt_d   = 2'd0;
            state_d = StMstart;
         end
         StMstart: begin
            state_d = StMwait;
`ifdef MAC_CTRL_TIMEOUT_EN
            wdog_d  = 8'd0;
`endif
         end
         StMwait: begin
            if (done3_i) begin
               state_d = StAcc;
`ifdef MAC_CTRL_TIMEOUT_EN
            end else if (wdog_expired) begin
               state_d = StAbort;
            end else begin
               wdog_d = wdog_q + 8'd1;
`endif
            end
         end
         StAcc: begin
            if (cnt_q == 2'd3) begin
               state_d = StFin;
            end else begin
               cnt_d   = cnt_q + 2'd1;
               state_d = StMstart;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
`ifdef MAC_CTRL_TIMEOUT_EN
         StAbort: begin
            state_d = StIdle;
         end
`endif
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Every strobe is a pure decode of the registered state, so none can leak across states.
   always_comb begin
      busy_o      = (state_q != StIdle);
      done_o      = 1'b0;
      err_o       = 1'b0;
      ld_x_o      = 4'h0;
      ld_y_o      = 4'h0;
      sel_xi_o    = 2'd0;
      sel_yi_o    = 2'd0;
      init_re_o   = 1'b0;
      init_imag_o = 1'b0;
      ld_re_o     = 1'b0;
      ld_imag_o   = 1'b0;
      start3_o    = 1'b0;
      case (state_q)
         StLoad: begin
            ld_x_o      = 4'hF;
            ld_y_o      = 4'hF;
            init_re_o   = 1'b1;
            init_imag_o = 1'b1;
         end
         StMstart: begin
            sel_xi_o = cnt_q;
            sel_yi_o = cnt_q;
            start3_o = 1'b1;
         end
         StMwait: begin
            sel_xi_o = cnt_q;
            sel_yi_o = cnt_q;
         end
         StAcc: begin
            sel_xi_o  = cnt_q;
            sel_yi_o  = cnt_q;
            ld_re_o   = 1'b1;
            ld_imag_o = 1'b1;
         end
         StFin: begin
            done_o = 1'b1;
         end
`ifdef MAC_CTRL_TIMEOUT_EN
         StAbort: begin
            err_o = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef MAC_CTRL_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wdog_q <= 8'd0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`endif

endmodule

// File: tb/tb_mac_ctrl.sv
// Scoreboard bench for mac_ctrl: expected per-cycle outputs are derived from cycle arithmetic
// and compared every cycle by an independent monitor; a reactive multiplier model drives done3.
module tb_mac_ctrl;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       start_i;
   logic       done3_i = 1'b0;
   logic       busy_o, done_o, err_o;
   logic [3:0] ld_x_o, ld_y_o;
   logic [1:0] sel_xi_o, sel_yi_o;
   logic       init_re_o, init_imag_o, ld_re_o, ld_imag_o, start3_o;

   always #5 clk = ~clk;

   mac_ctrl #(.TIMEOUT_CYC(16)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .start_i     (start_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .ld_x_o      (ld_x_o),
      .ld_y_o      (ld_y_o),
      .sel_xi_o    (sel_xi_o),
      .sel_yi_o    (sel_yi_o),
      .init_re_o   (init_re_o),
      .init_imag_o (init_imag_o),
      .ld_re_o     (ld_re_o),
      .ld_imag_o   (ld_imag_o),
      .start3_o    (start3_o),
      .done3_i     (done3_i)
   );

   typedef struct {
      int          cyc;
      logic [19:0] v;
   } ev_t;

   ev_t exp_q[$];
   int  lat_q[$];
   int  spur_q[$];
   int  due    = -1;
   int  cyc    = 0;
   int  total  = 0;
   int  bad    = 0;
   bit  mon_en = 1'b0;
   localparam int NoTrunc = 32'h7fff_ffff;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [19:0] mk(bit busy, bit dn, bit er, logic [3:0] ld, logic [1:0] sel,
                                      bit init, bit acc, bit st3);
      return {busy, dn, er, ld, ld, sel, sel, init, init, acc, acc, st3};
   endfunction

   function automatic void push_ev(int c, logic [19:0] v, int trunc);
      ev_t e;
      e.cyc = c;
      e.v   = v;
      if (c <= trunc) exp_q.push_back(e);
   endfunction

   // b is the IDLE cycle whose closing edge samples start; returns the cycle of the done pulse.
   function automatic int push_op(int b, int l0, int l1, int l2, int l3, int trunc);
      int lat[4];
      int s;
      lat = '{l0, l1, l2, l3};
      push_ev(b + 1, mk(1, 0, 0, 4'hF, 2'd0, 1, 0, 0), trunc);
      s = b + 2;
      for (int k = 0; k < 4; k++) begin
         push_ev(s, mk(1, 0, 0, 4'h0, 2'(k), 0, 0, 1), trunc);
         for (int j = 1; j <= lat[k]; j++) push_ev(s + j, mk(1, 0, 0, 4'h0, 2'(k), 0, 0, 0), trunc);
         push_ev(s + lat[k] + 1, mk(1, 0, 0, 4'h0, 2'(k), 0, 1, 0), trunc);
         s = s + lat[k] + 2;
      end
      push_ev(s, mk(1, 1, 0, 4'h0, 2'd0, 0, 0, 0), trunc);
      return s;
   endfunction

   // Multiplier model: done3 L cycles after each observed start3, plus injected spurious pulses.
   always @(negedge clk) begin
      done3_i = 1'b0;
      if (cyc == due) done3_i = 1'b1;
      foreach (spur_q[i]) if (spur_q[i] == cyc) done3_i = 1'b1;
      if (start3_o && lat_q.size() > 0) due = cyc + lat_q.pop_front();
   end

   // Monitor: every cycle the outputs must equal the scheduled event, or all zero otherwise.
   always @(negedge clk) begin
      if (mon_en) begin
         logic [19:0] expv;
         logic [19:0] got;
         ev_t         e;
         expv = 20'h0;
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e    = exp_q.pop_front();
            expv = e.v;
         end
         got = {busy_o, done_o, err_o, ld_x_o, ld_y_o, sel_xi_o, sel_yi_o,
                init_re_o, init_imag_o, ld_re_o, ld_imag_o, start3_o};
         total++;
         if (got !== expv) begin
            bad++;
            $display("FAIL outputs cyc=%0d got=%h required=%h", cyc, got, expv);
         end
      end
   end

   task automatic at_neg(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic pulse_op(input int l0, input int l1, input int l2, input int l3, output int f);
      int b;
      b = cyc;
      lat_q.push_back(l0);
      lat_q.push_back(l1);
      lat_q.push_back(l2);
      lat_q.push_back(l3);
      f = push_op(b, l0, l1, l2, l3, NoTrunc);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   initial begin
      int b, f, f2;
      rst_ni  = 1'b0;
      start_i = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      // Reset held with start high: outputs must stay quiet.
      repeat (3) @(negedge clk);

      // Nominal L=3, starting on reset release with start still high.
      rst_ni = 1'b1;
      pulse_op(3, 3, 3, 3, f);
      at_neg(f + 3);

      // Variable latency.
      pulse_op(1, 5, 2, 9, f);
      at_neg(f + 2);

      // Spurious done3 in LOAD and in two MSTART cycles.
      b = cyc;
      spur_q.push_back(b + 1);
      spur_q.push_back(b + 2);
      spur_q.push_back(b + 6);
      pulse_op(2, 2, 2, 2, f);
      at_neg(f + 2);
      spur_q.delete();

      // Reset during MWAIT of term 2, then a full restart.
      b = cyc;
      lat_q.push_back(2);
      lat_q.push_back(2);
      lat_q.push_back(8);
      lat_q.push_back(2);
      f = push_op(b, 2, 2, 8, 2, b + 13);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      at_neg(b + 13);
      rst_ni = 1'b0;
      lat_q.delete();
      due = -1;
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      pulse_op(1, 1, 1, 1, f);
      at_neg(f + 2);

      // Back-to-back: start held high through FIN.
      b = cyc;
      repeat (8) lat_q.push_back(1);
      f  = push_op(b, 1, 1, 1, 1, NoTrunc);
      f2 = push_op(f + 1, 1, 1, 1, 1, NoTrunc);
      start_i = 1'b1;
      at_neg(f + 2);
      start_i = 1'b0;
      at_neg(f2 + 2);

      // Randomised latencies, gaps and spurious LOAD-cycle done3.
      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if ($urandom_range(0, 1) == 1) spur_q.push_back(cyc + 1);
         pulse_op($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12),
                  $urandom_range(1, 12), f);
         at_neg(f + 1);
         spur_q.delete();
      end

`ifdef MAC_CTRL_TIMEOUT_EN
      // Watchdog: done3 never arrives; ABORT in the 17th cycle after start3.
      b = cyc;
      lat_q.push_back(100000);
      push_ev(b + 1, mk(1, 0, 0, 4'hF, 2'd0, 1, 0, 0), NoTrunc);
      push_ev(b + 2, mk(1, 0, 0, 4'h0, 2'd0, 0, 0, 1), NoTrunc);
      for (int j = 3; j <= 18; j++) push_ev(b + j, mk(1, 0, 0, 4'h0, 2'd0, 0, 0, 0), NoTrunc);
      push_ev(b + 19, mk(1, 0, 1, 4'h0, 2'd0, 0, 0, 0), NoTrunc);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      at_neg(b + 19);
      lat_q.delete();
      due = -1;
      at_neg(b + 22);
`endif

      at_neg(cyc + 3);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_events got=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
